// File: rtl/spi_slave.sv
// SPI slave serial front end: assembles 10-bit cmd+payload words from MOSI and shifts RAM read data out on MISO.
// Single clock domain; SS_n high at any posedge abandons the frame and returns to IDLE.
module spi_slave #(
    parameter int RX_WIDTH = 10,
    parameter int TX_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
);

    localparam int CW  = $clog2(RX_WIDTH + 1);
    localparam int TCW = $clog2(TX_WIDTH + 1);
    localparam logic [CW-1:0]  RX_LAST = CW'(RX_WIDTH - 1);
    localparam logic [CW-1:0]  RX_FULL = CW'(RX_WIDTH);
    localparam logic [TCW-1:0] TX_LAST = TCW'(TX_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [RX_WIDTH-2:0]   rx_sr_q;
    logic [RX_WIDTH-1:0]   rx_data_q;
    logic                  rx_valid_q;
    logic                  rd_addr_seen_q;
    logic [TX_WIDTH-1:0]   tx_sr_q;
    logic [TCW-1:0]        tx_cnt_q;
    logic                  tx_cap_q;
    logic                  miso_q;

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_sr_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_sr_q        <= '0;
            tx_cnt_q       <= '0;
            tx_cap_q       <= 1'b0;
            miso_q         <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q != IDLE && SS_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                tx_cnt_q <= '0;
                tx_cap_q <= 1'b0;
                miso_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!SS_n) begin
                            state_q  <= CHK_CMD;
                            cnt_q    <= '0;
                            tx_cnt_q <= '0;
                            tx_cap_q <= 1'b0;
                            miso_q   <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        rx_sr_q <= {{(RX_WIDTH-2){1'b0}}, MOSI};
                        cnt_q   <= CW'(1);
                        if (!MOSI)
                            state_q <= WRITE;
                        else if (rd_addr_seen_q)
                            state_q <= READ_DATA;
                        else
                            state_q <= READ_ADD;
                    end
                    default: begin
                        if (cnt_q < RX_FULL) begin
                            rx_sr_q <= {rx_sr_q[RX_WIDTH-3:0], MOSI};
                            cnt_q   <= cnt_q + CW'(1);
                            if (cnt_q == RX_LAST) begin
                                rx_data_q  <= {rx_sr_q, MOSI};
                                rx_valid_q <= 1'b1;
                                if (state_q == READ_ADD)
                                    rd_addr_seen_q <= 1'b1;
                                else if (state_q == READ_DATA)
                                    rd_addr_seen_q <= 1'b0;
                            end
                        end else if (state_q == READ_DATA) begin
                            // Only the first tx_valid of a read-data frame is taken; later ones are ignored.
                            if (tx_cnt_q != '0) begin
                                miso_q   <= tx_sr_q[TX_WIDTH-1];
                                tx_sr_q  <= tx_sr_q << 1;
                                tx_cnt_q <= tx_cnt_q - TCW'(1);
                            end else if (tx_valid && !tx_cap_q) begin
                                tx_cap_q <= 1'b1;
                                miso_q   <= tx_data[TX_WIDTH-1];
                                tx_sr_q  <= {tx_data[TX_WIDTH-2:0], 1'b0};
                                tx_cnt_q <= TX_LAST;
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave against a frame-level model of command decoding and readback.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         pulses;
    logic [9:0] got;
    bit         m_seen;
    logic [9:0] m_last;

    always #5 clk = ~clk;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rx_valid === 1'b1) begin
            pulses++;
            got = rx_data;
        end
    endtask

    // nbits<10 aborts the frame; abort_tx>0 raises SS_n after that many readback bits.
    task automatic run_frame(input logic [9:0] w, input int nbits, input bit send_tx,
                             input logic [7:0] txd, input int txdly, input int abort_tx);
        int   miso_hi;
        bit   rd;
        logic exp_bit;
        miso_hi  = 0;
        pulses   = 0;
        SS_n     = 1'b0;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI     = w[9-i];
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            tick();
            miso_hi += int'(MISO);
            if (i == 8) check("rx_early", 32'(pulses), 32'd0);
        end
        tx_valid = 1'b0;
        if (nbits < 10) begin
            SS_n = 1'b1;
            tick();
            miso_hi += int'(MISO);
            check("abort_no_valid", 32'(pulses), 32'd0);
            check("abort_rx_hold", 32'(rx_data), 32'(m_last));
            check("abort_miso", 32'(miso_hi), 32'd0);
        end else begin
            check("rx_valid_cnt", 32'(pulses), 32'd1);
            check("rx_data", 32'(got), 32'(w));
            check("miso_quiet", 32'(miso_hi), 32'd0);
            rd = w[9] && m_seen;
            if (w[9]) m_seen = m_seen ? 1'b0 : 1'b1;
            m_last = w;
            if (send_tx) begin
                for (int d = 0; d < txdly; d++) begin
                    MOSI = 1'($urandom);
                    tick();
                    check("miso_wait", 32'(MISO), 32'd0);
                end
                tx_valid = 1'b1;
                tx_data  = txd;
                tick();
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
                for (int j = 0; j < 12; j++) begin
                    exp_bit = (rd && j < 8 && (abort_tx == 0 || j < abort_tx)) ? txd[7-j] : 1'b0;
                    check($sformatf("miso_bit%0d", j), 32'(MISO), 32'(exp_bit));
                    if (j == 1) begin
                        tx_valid = 1'b1;
                        tx_data  = ~txd;
                    end else begin
                        tx_valid = 1'b0;
                    end
                    if (abort_tx != 0 && j == abort_tx - 1) SS_n = 1'b1;
                    tick();
                end
            end
            SS_n     = 1'b1;
            tx_valid = 1'b0;
            tick();
            check("miso_end", 32'(MISO), 32'd0);
            check("rx_single", 32'(pulses), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        m_seen   = 1'b0;
        m_last   = '0;
        pulses   = 0;
        repeat (2) @(negedge clk);
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(10'h001, 10, 1'b1, 8'h5A, 2, 0);
        run_frame(10'h1AA, 10, 1'b0, 8'h00, 0, 0);
        run_frame(10'h201, 10, 1'b1, 8'h77, 1, 0);
        run_frame(10'h300, 10, 1'b1, 8'hA5, 1, 0);
        run_frame(10'h2FF, 6,  1'b0, 8'h00, 0, 0);
        run_frame(10'h200, 10, 1'b1, 8'h3C, 2, 0);
        run_frame(10'h3C3, 10, 1'b1, 8'h81, 3, 3);

        run_frame(10'h205, 10, 1'b0, 8'h00, 0, 0);
        pulses = 0;
        SS_n   = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_miso", 32'(MISO), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        m_seen = 1'b0;
        m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        SS_n  = 1'b1;
        tick();
        check("rst_no_valid", 32'(pulses), 32'd0);
        run_frame(10'h3FF, 10, 1'b1, 8'hFF, 1, 0);

        for (int f = 0; f < 40; f++) begin
            logic [9:0] w;
            int         nb;
            int         ab;
            w  = 10'($urandom_range(0, 1023));
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 10;
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_frame(w, nb, 1'($urandom), 8'($urandom), int'($urandom_range(1, 4)), ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
